// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and sequencer that shares one WIDTH-bit D flip-flop bank
// among N_REQ requesters over a req/gnt/ack handshake; every output is registered.
module dff_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   ack,
  output logic                   err,
  output logic                   busy,
  output logic                   bank_clr,
  output logic                   bank_st,
  output logic                   bank_ld,
  output logic [WIDTH-1:0]       bank_d
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_BAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               bank_clr_q, bank_clr_d;
  logic               bank_st_q, bank_st_d;
  logic               bank_ld_q, bank_ld_d;
  logic [WIDTH-1:0]   bank_d_q, bank_d_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   data_sel;
  logic               apply_d;
  int                 idx;

  // Search upward from ptr, wrapping past N_REQ-1 to 0; first requester found wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    op_sel   = '0;
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == pick) begin
        op_sel   = op[2*i +: 2];
        data_sel = wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          op_d    = op_sel;
          data_d  = data_sel;
          ptr_d   = (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + IDX_W'(1);
          state_d = GRANT;
        end
      end
      // A requester that drops req while granted aborts; ptr stays advanced.
      GRANT:   state_d = req[win_q] ? APPLY : IDLE;
      APPLY:   state_d = ACK;
      ACK:     if (!req[win_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle the FSM enters that state.
  always_comb begin
    gnt_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state_d != IDLE && IDX_W'(i) == win_d) gnt_d[i] = 1'b1;
    end
    apply_d    = (state_d == APPLY);
    ack_d      = (state_d == ACK);
    busy_d     = (state_d != IDLE);
    bank_ld_d  = apply_d && (op_d == OP_LOAD);
    bank_st_d  = apply_d && (op_d == OP_SET);
    bank_clr_d = apply_d && (op_d == OP_CLEAR);
    err_d      = apply_d && (op_d == OP_BAD);
    bank_d_d   = apply_d ? data_d : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    if (clr) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      op_q       <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      bank_clr_q <= 1'b0;
      bank_st_q  <= 1'b0;
      bank_ld_q  <= 1'b0;
      bank_d_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      op_q       <= op_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      bank_clr_q <= bank_clr_d;
      bank_st_q  <= bank_st_d;
      bank_ld_q  <= bank_ld_d;
      bank_d_q   <= bank_d_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign bank_clr = bank_clr_q;
  assign bank_st  = bank_st_q;
  assign bank_ld  = bank_ld_q;
  assign bank_d   = bank_d_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: a per-cycle vector table plus hand-written
// round-robin, abort and mid-operation reset sequences.
module tb_dff_bank_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   clr;
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   ack, err, busy, bank_clr, bank_st, bank_ld;
  logic [WIDTH-1:0]       bank_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .op       (op),
    .wdata    (wdata),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .bank_clr (bank_clr),
    .bank_st  (bank_st),
    .bank_ld  (bank_ld),
    .bank_d   (bank_d)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       ack, err, busy, bank_clr, bank_st, bank_ld;
    logic [7:0] bank_d;
  } out_t;

  typedef struct {
    string       name;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    out_t        exp;
  } vec_t;

  vec_t vq[$];

  function automatic out_t mk(logic [3:0] g, logic a, logic e, logic b,
                              logic c, logic s, logic l, logic [7:0] d);
    out_t o;
    o.gnt = g; o.ack = a; o.err = e; o.busy = b;
    o.bank_clr = c; o.bank_st = s; o.bank_ld = l; o.bank_d = d;
    return o;
  endfunction

  function automatic out_t cur();
    return mk(gnt, ack, err, busy, bank_clr, bank_st, bank_ld, bank_d);
  endfunction

  function automatic vec_t mkv(string n, logic c, logic [3:0] r, logic [7:0] o,
                               logic [31:0] w, out_t e);
    vec_t v;
    v.name = n; v.clr = c; v.req = r; v.op = o; v.wdata = w; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    req = '0;
    tick();
    clr = 1'b0;
  endtask

  localparam logic [31:0] WD = 32'h00A5_003C;
  localparam out_t        Z  = '0;

  initial begin
    int n;
    clr = 1'b1; req = '0; op = '0; wdata = '0;
    tick();

    // Single load by requester 2, then set/clear/invalid by requester 0 (bank_d = 3C).
    vq.push_back(mkv("reset",     1, 4'b0000, 8'h00, WD, Z));
    vq.push_back(mkv("ld_grant",  0, 4'b0100, 8'h00, WD, mk(4'b0100, 0, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("ld_apply",  0, 4'b0100, 8'h00, WD, mk(4'b0100, 0, 0, 1, 0, 0, 1, 8'hA5)));
    vq.push_back(mkv("ld_ack",    0, 4'b0100, 8'h00, WD, mk(4'b0100, 1, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("ld_ack2",   0, 4'b0100, 8'h00, WD, mk(4'b0100, 1, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("ld_idle",   0, 4'b0000, 8'h00, WD, Z));
    vq.push_back(mkv("st_grant",  0, 4'b0001, 8'h01, WD, mk(4'b0001, 0, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("st_apply",  0, 4'b0001, 8'h01, WD, mk(4'b0001, 0, 0, 1, 0, 1, 0, 8'h3C)));
    vq.push_back(mkv("st_ack",    0, 4'b0001, 8'h01, WD, mk(4'b0001, 1, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("st_idle",   0, 4'b0000, 8'h01, WD, Z));
    vq.push_back(mkv("cl_grant",  0, 4'b0001, 8'h02, WD, mk(4'b0001, 0, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("cl_apply",  0, 4'b0001, 8'h02, WD, mk(4'b0001, 0, 0, 1, 1, 0, 0, 8'h3C)));
    vq.push_back(mkv("cl_ack",    0, 4'b0001, 8'h02, WD, mk(4'b0001, 1, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("cl_idle",   0, 4'b0000, 8'h02, WD, Z));
    vq.push_back(mkv("bad_grant", 0, 4'b0001, 8'h03, WD, mk(4'b0001, 0, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("bad_apply", 0, 4'b0001, 8'h03, WD, mk(4'b0001, 0, 1, 1, 0, 0, 0, 8'h3C)));
    vq.push_back(mkv("bad_ack",   0, 4'b0001, 8'h03, WD, mk(4'b0001, 1, 0, 1, 0, 0, 0, 8'h00)));
    vq.push_back(mkv("bad_idle",  0, 4'b0000, 8'h03, WD, Z));

    foreach (vq[k]) begin
      clr = vq[k].clr; req = vq[k].req; op = vq[k].op; wdata = vq[k].wdata;
      tick();
      check(vq[k].name, 32'(cur()), 32'(vq[k].exp));
    end

    // Round-robin with all four requesting; each drops after ack and re-raises.
    do_reset();
    op = '0; wdata = 32'h1122_3344; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == '0 && n < 20) begin tick(); n++; end
      check($sformatf("rr_grant%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
      n = 0;
      while (!ack && n < 20) begin tick(); n++; end
      check($sformatf("rr_ack%0d", k), 32'(ack), 32'd1);
      req[k % 4] = 1'b0;
      tick();
      req[k % 4] = 1'b1;
    end

    // Abort: requester 1 drops req during GRANT; ptr must stay at 2.
    do_reset();
    op = '0; wdata = WD; req = 4'b0010;
    tick();
    check("abort_grant", 32'(cur()), 32'(mk(4'b0010, 0, 0, 1, 0, 0, 0, 8'h00)));
    req = 4'b0000;
    tick();
    check("abort_idle", 32'(cur()), 32'(Z));
    tick();
    check("abort_quiet", 32'(cur()), 32'(Z));
    req = 4'b0011;
    tick();
    check("abort_next", 32'(cur()), 32'(mk(4'b0001, 0, 0, 1, 0, 0, 0, 8'h00)));

    // Reset during APPLY of requester 3, which keeps requesting afterwards.
    do_reset();
    op = '0; wdata = 32'h5A00_0000; req = 4'b1000;
    tick();
    tick();
    check("mid_apply", 32'(cur()), 32'(mk(4'b1000, 0, 0, 1, 0, 0, 1, 8'h5A)));
    clr = 1'b1;
    tick();
    check("mid_reset", 32'(cur()), 32'(Z));
    clr = 1'b0;
    tick();
    check("mid_regrant", 32'(cur()), 32'(mk(4'b1000, 0, 0, 1, 0, 0, 0, 8'h00)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
